alu_adder_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational ALU adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling a registered carry between chunks.
- Reports Sum, carry-out, signed overflow and zero flags, using a start/busy/done handshake.
- Sits in the MIPS-32 ALU datapath for area-constrained builds, and serves as a reusable add/sub unit.

---
 rtl/alu_adder_seq.sv | 76 +++++++
 tb/tb_alu_adder_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_adder_seq.sv
// alu_adder_seq: multi-cycle add/sub, CHUNK bits per clock with rippled carry and start/busy/done handshake
module alu_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] op_a, op_b, part, full;
  logic carry, last, accept, ovf;
  logic [CHUNK:0] csum;
  assign csum = {1'b0, op_a[idx*CHUNK +: CHUNK]} + {1'b0, op_b[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
  assign last = idx == IW'(N - 1);
  assign accept = state == IDLE && start;
  assign busy = state == RUN;
  assign ovf = full[WIDTH-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ csum[CHUNK];
  always_comb begin
    full = part;
    full[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
  end
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (state == RUN && last) state_nx = IDLE;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      part  <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a  <= A;
        op_b  <= B ^ {WIDTH{sub}};
        carry <= sub;
        part  <= '0;
        idx   <= '0;
      end else if (state == RUN) begin
        part  <= full;
        carry <= csum[CHUNK];
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          Sum  <= full;
          Cout <= csum[CHUNK];
          Ovf  <= ovf;
          Zero <= full == '0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_adder_seq.sv
// tb_alu_adder_seq: directed self-checking bench over three alu_adder_seq configurations
module tb_alu_adder_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic r8, st8, sb8, bz8, dn8, co8, ov8, zr8;
  logic [7:0] a8, b8, sm8;
  logic r32, st32, sb32, bz32, dn32, co32, ov32, zr32;
  logic [31:0] a32, b32, sm32;
  logic r1, st1, sb1, bz1, dn1, co1, ov1, zr1;
  logic [7:0] a1, b1, sm1;
  alu_adder_seq #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(r8), .start(st8), .sub(sb8), .A(a8), .B(b8),
    .busy(bz8), .done(dn8), .Sum(sm8), .Cout(co8), .Ovf(ov8), .Zero(zr8)
  );
  alu_adder_seq #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(r32), .start(st32), .sub(sb32), .A(a32), .B(b32),
    .busy(bz32), .done(dn32), .Sum(sm32), .Cout(co32), .Ovf(ov32), .Zero(zr32)
  );
  alu_adder_seq #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(r1), .start(st1), .sub(sb1), .A(a1), .B(b1),
    .busy(bz1), .done(dn1), .Sum(sm1), .Cout(co1), .Ovf(ov1), .Zero(zr1)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s);
    st8 = 1'b1; a8 = a; b8 = b; sb8 = s;
    tick;
    st8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; sb8 = ~s;
  endtask
  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s);
    st32 = 1'b1; a32 = a; b32 = b; sb32 = s;
    tick;
    st32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D; sb32 = ~s;
  endtask
  task automatic go1(input logic [7:0] a, input logic [7:0] b, input logic s);
    st1 = 1'b1; a1 = a; b1 = b; sb1 = s;
    tick;
    st1 = 1'b0; a1 = 8'h3C; b1 = 8'hC3; sb1 = ~s;
  endtask
  task automatic wait8(output int n);
    n = 0;
    while (!dn8 && n < 20) begin tick; n++; end
  endtask
  task automatic wait32(input int n0, output int n);
    n = n0;
    while (!dn32 && n < 20) begin tick; n++; end
  endtask
  task automatic wait1(output int n);
    n = 0;
    while (!dn1 && n < 20) begin tick; n++; end
  endtask
  task automatic test_reset;
    r8 = 0; r32 = 0; r1 = 0;
    st8 = 1; sb8 = 1; a8 = 8'hFF; b8 = 8'h01;
    st32 = 1; sb32 = 1; a32 = '1; b32 = 32'h1;
    st1 = 1; sb1 = 1; a1 = 8'hFF; b1 = 8'h01;
    tick; tick;
    checks++;
    if ({bz8, dn8, sm8, co8, ov8, zr8} !== 13'h0) begin
      errors++; $display("FAIL reset_w8c4: got %h exp 0", {bz8, dn8, sm8, co8, ov8, zr8});
    end
    checks++;
    if ({bz32, dn32, sm32, co32, ov32, zr32} !== 37'h0) begin
      errors++; $display("FAIL reset_w32c8: got %h exp 0", {bz32, dn32, sm32, co32, ov32, zr32});
    end
    checks++;
    if ({bz1, dn1, sm1, co1, ov1, zr1} !== 13'h0) begin
      errors++; $display("FAIL reset_w8c8: got %h exp 0", {bz1, dn1, sm1, co1, ov1, zr1});
    end
    st8 = 0; st32 = 0; st1 = 0; sb8 = 0; sb32 = 0; sb1 = 0;
    r8 = 1; r32 = 1; r1 = 1;
    tick;
  endtask
  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'd81, 8'd226, 8'd197};
    logic [7:0] vb [3] = '{8'd135, 8'd159, 8'd0};
    logic [10:0] ev [3] = '{{8'd216, 3'b000}, {8'd129, 3'b100}, {8'd197, 3'b000}};
    int n;
    for (int i = 0; i < 3; i++) begin
      go8(va[i], vb[i], 1'b0);
      if (i > 0) begin
        checks++;
        if (sm8 !== ev[i-1][10:3]) begin
          errors++; $display("FAIL b2b_hold_%0d: got %0d exp %0d", i, sm8, ev[i-1][10:3]);
        end
      end
      wait8(n);
      checks++;
      if (n !== 2) begin
        errors++; $display("FAIL b2b_latency_%0d: got %0d exp 2", i, n);
      end
      checks++;
      if ({sm8, co8, ov8, zr8} !== ev[i]) begin
        errors++; $display("FAIL b2b_result_%0d: got %h exp %h", i, {sm8, co8, ov8, zr8}, ev[i]);
      end
    end
    tick;
    checks++;
    if (dn8 !== 1'b0) begin
      errors++; $display("FAIL b2b_done_pulse: got %b exp 0", dn8);
    end
  endtask
  task automatic test_ovf_sub;
    logic [7:0] va [5] = '{8'd126, 8'd125, 8'd70, 8'd21, 8'h80};
    logic [7:0] vb [5] = '{8'd2, 8'd142, 8'd83, 8'd21, 8'h01};
    logic vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [10:0] ev [5] = '{{8'h80, 3'b010}, {8'd11, 3'b100}, {8'hF3, 3'b000}, {8'h00, 3'b101}, {8'h7F, 3'b110}};
    int n;
    for (int i = 0; i < 5; i++) begin
      go8(va[i], vb[i], vs[i]);
      wait8(n);
      checks++;
      if ({sm8, co8, ov8, zr8} !== ev[i] || n !== 2) begin
        errors++; $display("FAIL ovf_sub_%0d: got %h lat %0d exp %h lat 2", i, {sm8, co8, ov8, zr8}, n, ev[i]);
      end
    end
  endtask
  task automatic test_wide_ignore;
    int n;
    go32(32'hFFFFFFFF, 32'h1, 1'b0);
    checks++;
    if (bz32 !== 1'b1) begin
      errors++; $display("FAIL wide_busy_0: got %b exp 1", bz32);
    end
    tick;
    checks++;
    if (bz32 !== 1'b1) begin
      errors++; $display("FAIL wide_busy_1: got %b exp 1", bz32);
    end
    st32 = 1'b1; a32 = 32'd3; b32 = 32'd4; sb32 = 1'b0;
    tick;
    st32 = 1'b0;
    checks++;
    if (bz32 !== 1'b1 || dn32 !== 1'b0) begin
      errors++; $display("FAIL wide_busy_2: got busy %b done %b exp 1 0", bz32, dn32);
    end
    wait32(2, n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL wide_latency: got %0d exp 4", n);
    end
    checks++;
    if ({sm32, co32, ov32, zr32} !== {32'h0, 3'b101}) begin
      errors++; $display("FAIL wide_result: got %h exp %h", {sm32, co32, ov32, zr32}, {32'h0, 3'b101});
    end
    tick;
    checks++;
    if (bz32 !== 1'b0 || dn32 !== 1'b0) begin
      errors++; $display("FAIL wide_not_queued: got busy %b done %b exp 0 0", bz32, dn32);
    end
  endtask
  task automatic test_abort;
    int n;
    logic seen;
    go32(32'h12345678, 32'h1, 1'b0);
    tick;
    r32 = 1'b0;
    tick;
    checks++;
    if ({bz32, dn32, sm32, co32, ov32, zr32} !== 37'h0) begin
      errors++; $display("FAIL abort_clear: got %h exp 0", {bz32, dn32, sm32, co32, ov32, zr32});
    end
    r32 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick; seen |= dn32 | bz32; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got %b exp 0", seen);
    end
    go32(32'd5, 32'd7, 1'b0);
    wait32(0, n);
    checks++;
    if ({sm32, co32, ov32, zr32} !== {32'd12, 3'b000} || n !== 4) begin
      errors++; $display("FAIL abort_restart: got %h lat %0d exp %h lat 4", {sm32, co32, ov32, zr32}, n, {32'd12, 3'b000});
    end
  endtask
  task automatic test_single;
    int n;
    go1(8'd10, 8'd20, 1'b0);
    wait1(n);
    checks++;
    if (n !== 1 || sm1 !== 8'd30) begin
      errors++; $display("FAIL single_first: got %0d lat %0d exp 30 lat 1", sm1, n);
    end
    go1(8'd231, 8'd119, 1'b0);
    checks++;
    if (bz1 !== 1'b1 || dn1 !== 1'b0 || sm1 !== 8'd30) begin
      errors++; $display("FAIL single_run: got busy %b done %b sum %0d exp 1 0 30", bz1, dn1, sm1);
    end
    tick;
    checks++;
    if (bz1 !== 1'b0 || dn1 !== 1'b1 || {sm1, co1, ov1, zr1} !== {8'd94, 3'b100}) begin
      errors++; $display("FAIL single_done: got busy %b done %b res %h exp 0 1 %h", bz1, dn1, {sm1, co1, ov1, zr1}, {8'd94, 3'b100});
    end
    tick;
    checks++;
    if (dn1 !== 1'b0 || sm1 !== 8'd94) begin
      errors++; $display("FAIL single_after: got done %b sum %0d exp 0 94", dn1, sm1);
    end
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_ovf_sub;
    test_wide_ignore;
    test_abort;
    test_single;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
